fft_frame_sequencer: RTL
========================

# fft_frame_sequencer

Controller sitting between the XADC DRP read port and the Xilinx FFT core's AXI-Stream slave ports. After reset it issues the FFT configuration word, then converts each XADC conversion result into a signed complex sample and streams it to the FFT in NFFT-sample frames with a correct tlast. A small FIFO absorbs FFT backpressure, and the block reports overflow, protocol errors and completed output frames to the LED/display logic.

## Interface
- NFFT, 256, points per frame; power of two, 8..65536
- FIFO_DEPTH, 4, sample FIFO entries; power of two, >=2
- CFG_WORD, 8'h01, value driven on cfg_tdata
- CLK100MHZ  in  1  system clock
- reset  in  1  asynchronous, active-high; all state cleared
- run  in  1  level; 1 = stream frames, 0 = stop at next frame boundary
- clr_flags  in  1  pulse; clears overflow and proto_err
- adc_drdy  in  1  XADC DRP data-ready pulse
- adc_do  in  16  XADC result; 12-bit code in [15:4]
- cfg_tvalid  out  1 / cfg_tready  in  1 / cfg_tdata  out  8  FFT config channel
- din_tvalid  out  1 / din_tready  in  1 / din_tdata  out  32 / din_tlast  out  1  FFT data-in channel
- dout_tvalid  in  1 / dout_tready  out  1 / dout_tlast  in  1  FFT data-out channel (monitored; dout_tready tied to 1)
- evt_tlast_unexpected  in  1 / evt_tlast_missing  in  1  FFT event pulses
- frame_count  out  16  output frames completed, wraps at 16'hFFFF
- overflow  out  1  sticky: sample dropped because the FIFO was full
- proto_err  out  1  sticky: FFT reported a tlast event
- busy  out  1  1 in any state other than IDLE, or while the FIFO is non-empty

## Operation
- States: CFG, IDLE, RUN, STOP.
- CFG: cfg_tvalid=1 and cfg_tdata=CFG_WORD. Leave CFG for IDLE on the edge where cfg_tvalid&&cfg_tready. Samples are ignored in CFG.
- IDLE: no samples accepted. Go to RUN when run=1; the sample index is always 0 here.
- RUN: every adc_drdy pushes one sample. When run=0, go to STOP; if the index is 0, go straight to IDLE.
- STOP: keep accepting samples until the push with index NFFT-1, then go to IDLE. The frame always completes.
- Sample conversion:
  - code = {~adc_do[15], adc_do[14:4]}, i.e. offset binary converted to signed 12-bit.
  - real = sign-extended code, 16 bits.
  - din_tdata = {16'h0000 (imag), real}.
- Sample index: increments on each successful push and wraps NFFT-1 -> 0. The FIFO entry stores tlast = (index == NFFT-1).
- FIFO push rule: a push is allowed when the FIFO is not full, or when a pop (din_tvalid&&din_tready) happens in the same cycle.
- Dropped sample: a drdy that cannot push is dropped, overflow is set, and the index does not advance, so frame alignment is preserved.
- din_tvalid = FIFO non-empty. The head entry is held stable until accepted.
- frame_count increments on each dout_tvalid&&dout_tlast.
- proto_err is set on any evt_tlast_* pulse.
- clr_flags clears overflow and proto_err. A set event in the same cycle as clr_flags wins.

## Timing
- Reset values: cfg_tvalid=0, din_tvalid=0, din_tlast=0, din_tdata=0, frame_count=0, overflow=0, proto_err=0, busy=1, dout_tready=1. After reset the state is CFG and the index is 0.
- cfg_tvalid is registered and rises on the first CLK100MHZ edge after reset deasserts.
- Latency: a drdy at edge k into an empty FIFO gives din_tvalid=1 after edge k (visible in cycle k+1).
- Throughput: one sample per cycle at most.
- FIFO full-to-empty and wrap are pointer-based with no bubble. The FIFO holds exactly FIFO_DEPTH entries.
- Asserting reset mid-frame flushes the FIFO and partial frame immediately. After release the config is re-sent.

## Test plan
- Reset release with cfg_tready held 0 for 5 cycles, then 1 -> cfg_tvalid=1 with cfg_tdata=8'h01 for 6 cycles, drops after the handshake edge, state IDLE.
- RUN, din_tready=1, adc_do=16'hFFF0, 16'h0000, 16'h8000 -> din_tdata = 32'h000007FF, 32'h0000F800, 32'h00000000, each one cycle after its drdy.
- NFFT=8, 20 drdy pulses, run dropped after the 10th -> 16 samples out, din_tlast on samples 8 and 16, state IDLE, busy=0 once drained.
- din_tready=0 with 6 drdy pulses (FIFO_DEPTH=4) -> 4 stored, overflow=1. Release din_tready: 4 samples out, and the next frame's tlast lands on the NFFT-th accepted sample. clr_flags clears overflow.
- FIFO full, drdy and pop in the same cycle -> push accepted, no overflow.
- Three dout_tvalid&&dout_tlast pulses -> frame_count=3. evt_tlast_missing pulse -> proto_err=1. Reset mid-frame -> all outputs at reset values, config re-sent.

Source files
------------

// File: rtl/fft_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sequencer_if
// Purpose  : AXI-Stream config, data-in, data-out and event lines of the FFT core.
// Revision : 1.0
// ============================================================================
interface fft_frame_sequencer_if;
   logic        cfg_tvalid;
   logic        cfg_tready;
   logic [7:0]  cfg_tdata;
   logic        din_tvalid;
   logic        din_tready;
   logic [31:0] din_tdata;
   logic        din_tlast;
   logic        dout_tvalid;
   logic        dout_tready;
   logic        dout_tlast;
   logic        evt_tlast_unexpected;
   logic        evt_tlast_missing;

   modport master (
      output cfg_tvalid, cfg_tdata,
      input  cfg_tready,
      output din_tvalid, din_tdata, din_tlast,
      input  din_tready,
      input  dout_tvalid, dout_tlast,
      output dout_tready,
      input  evt_tlast_unexpected, evt_tlast_missing
   );

   modport slave (
      input  cfg_tvalid, cfg_tdata,
      output cfg_tready,
      input  din_tvalid, din_tdata, din_tlast,
      output din_tready,
      output dout_tvalid, dout_tlast,
      input  dout_tready,
      output evt_tlast_unexpected, evt_tlast_missing
   );
endinterface
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sequencer
// Purpose  : Configures the FFT core, then streams XADC samples in NFFT frames.
// Revision : 1.0
// ============================================================================
module fft_frame_sequencer #(
   parameter int         NFFT       = 256,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] CFG_WORD   = 8'h01
) (
   input  logic                  CLK100MHZ,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  clr_flags,
   input  logic                  adc_drdy,
   input  logic [15:0]           adc_do,
   fft_frame_sequencer_if.master fft,
   output logic [15:0]           frame_count,
   output logic                  overflow,
   output logic                  proto_err,
   output logic                  busy
);

   localparam int c_idx_w = $clog2(NFFT);
   localparam int c_aw    = $clog2(FIFO_DEPTH);
   localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NFFT - 1);
   localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
   localparam logic [c_aw:0]      c_ptr_one  = (c_aw + 1)'(1);

   typedef enum logic [1:0] {
      ST_CFG  = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   state_t               r_state;
   logic                 r_cfg_tvalid;
   logic [c_idx_w-1:0]   r_idx;
   logic [16:0]          r_mem [FIFO_DEPTH];
   logic [c_aw:0]        r_wr_ptr;
   logic [c_aw:0]        r_rd_ptr;
   logic                 r_overflow;
   logic                 r_proto_err;
   logic [15:0]          r_frame_count;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_accepting;
   logic                 w_push;
   logic                 w_drop;
   logic [c_idx_w-1:0]   w_idx_next;
   logic [11:0]          w_code;
   logic [15:0]          w_real;
   logic [16:0]          w_head;
   logic                 w_unused;

   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
   assign w_pop       = !w_empty && fft.din_tready;
   assign w_accepting = (r_state == ST_RUN) || (r_state == ST_STOP);
   // A full FIFO still takes a sample when the head leaves in the same cycle
   assign w_push      = adc_drdy && w_accepting && (!w_full || w_pop);
   assign w_drop      = adc_drdy && w_accepting && !w_push;
   assign w_idx_next  = w_push ? (r_idx + c_idx_one) : r_idx;

   // Offset-binary XADC code to two's complement, then sign-extend
   assign w_code   = {~adc_do[15], adc_do[14:4]};
   assign w_real   = {{4{w_code[11]}}, w_code};
   assign w_unused = ^adc_do[3:0];

   assign w_head = r_mem[r_rd_ptr[c_aw-1:0]];

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         r_state      <= ST_CFG;
         r_cfg_tvalid <= 1'b0;
         r_idx        <= '0;
      end else begin
         r_idx <= w_idx_next;
         case (r_state)
            ST_CFG: begin
               if (r_cfg_tvalid && fft.cfg_tready) begin
                  r_cfg_tvalid <= 1'b0;
                  r_state      <= ST_IDLE;
               end else begin
                  r_cfg_tvalid <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (run) r_state <= ST_RUN;
            end
            ST_RUN: begin
               // Stopping exactly on a frame boundary needs no drain phase
               if (!run) r_state <= (w_idx_next == '0) ? ST_IDLE : ST_STOP;
            end
            ST_STOP: begin
               if (w_push && (r_idx == c_idx_last)) r_state <= ST_IDLE;
            end
            default: r_state <= ST_CFG;
         endcase
      end
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_overflow    <= 1'b0;
         r_proto_err   <= 1'b0;
         r_frame_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= {(r_idx == c_idx_last), w_real};
            r_wr_ptr                  <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         if (w_drop)         r_overflow <= 1'b1;
         else if (clr_flags) r_overflow <= 1'b0;
         if (fft.evt_tlast_unexpected || fft.evt_tlast_missing) r_proto_err <= 1'b1;
         else if (clr_flags)                                    r_proto_err <= 1'b0;
         if (fft.dout_tvalid && fft.dout_tlast) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   assign fft.cfg_tvalid  = r_cfg_tvalid;
   assign fft.cfg_tdata   = CFG_WORD;
   assign fft.din_tvalid  = !w_empty;
   assign fft.din_tdata   = {16'h0000, w_head[15:0]};
   assign fft.din_tlast   = w_head[16];
   assign fft.dout_tready = 1'b1;

   assign frame_count = r_frame_count;
   assign overflow    = r_overflow;
   assign proto_err   = r_proto_err;
   assign busy        = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire
